rst_perst_seq: RTL
==================

# rst_perst_seq

Parametrised PCIe PERST# generator and successor to the plain override/default PERST table. For each channel it selects between a default request and a per-channel debug override, exactly as before. It adds two new behaviours: a guaranteed minimum PERST# assertion width per channel, and a global staggered-release scheduler that deasserts channels one at a time, lowest index first, to limit inrush and link-training bursts. It sits in the common reset block between the PERST table control registers and the PERST# output pins.

## Interface
Parameters:
- NUM_PCIE_SIGNALS, 7, number of PERST# channels (1..32).
- MIN_ASSERT_CNT, 200, minimum PERST# low time in iClk cycles (>=1). 200 cycles is 100 us at 2 MHz.
- STAGGER_CNT, 20, minimum spacing in cycles between successive scheduled releases. 0 disables staggering: all eligible channels release together.

Ports:
- iClk, in, 1, system clock (2 MHz).
- iRst_n, in, 1, reset. One clock; reset is synchronous and active-low, sampled on the rising edge of iClk.
- ivOverride_Enable, in, NUM_PCIE_SIGNALS, per-channel override enable.
- ivOvrValues, in, NUM_PCIE_SIGNALS, override PERST# level (1 = deasserted).
- ivDefaultValues, in, NUM_PCIE_SIGNALS, requested PERST# level when not overridden.
- ovRstPCIePERst_n, out, NUM_PCIE_SIGNALS, registered PERST# outputs (active-low).
- ovReleasePending, out, NUM_PCIE_SIGNALS, registered; channel requests release but is still held low.
- oStaggerBusy, out, 1, registered; stagger window counter is nonzero.

## Operation
- Effective request: eff[i] = ivOverride_Enable[i] ? ivOvrValues[i] : ivDefaultValues[i]. This is combinational from the inputs.
- Per-channel down-counter aCnt[i], width $clog2(MIN_ASSERT_CNT).
  - Loaded with MIN_ASSERT_CNT-1 on every 1->0 transition of out[i].
  - Otherwise decrements while out[i]=0 and aCnt[i]!=0.
  - Holds at 0.
- Global down-counter sCnt, width $clog2(STAGGER_CNT+1).
  - Loaded with STAGGER_CNT-1 on a scheduled grant.
  - Otherwise decrements to 0.
- Assertion: if eff[i]=0, out[i] goes 0 at the next edge. There is no gating; assertion always wins.
- Override channels (ivOverride_Enable[i]=1):
  - out[i] follows eff[i] at the next edge in both directions.
  - They bypass both aCnt and sCnt and never consume a stagger slot.
  - aCnt[i] is still reloaded on their falling edge.
- Scheduled channels (override disabled): eligible[i] = out[i]=0 & eff[i]=1 & aCnt[i]=0.
  - STAGGER_CNT>0: when sCnt=0, the lowest-index eligible channel is granted. Its out goes 1 at the next edge and sCnt is reloaded.
  - STAGGER_CNT=0: all eligible channels are granted in the same cycle.
- Simultaneous events:
  - A channel whose eff falls in its grant cycle is not eligible. The grant passes to the next eligible index in the same cycle.
  - Toggling eff while out is already low does not reload aCnt.
  - An override enable dropping while out=0 turns the channel into a normal scheduled channel, gated by aCnt and sCnt.
- ovReleasePending[i] registers (out_next[i]=0 & eff[i]=1 & ~ivOverride_Enable[i]).
- oStaggerBusy registers (sCnt_next != 0).

## Timing
- Reset (iRst_n=0 at an edge) drives:
  - ovRstPCIePERst_n = 0 (all asserted)
  - ovReleasePending = 0
  - oStaggerBusy = 0
  - aCnt[i] = MIN_ASSERT_CNT-1 for all i, so the minimum width applies from reset
  - sCnt = 0
- Reset taken mid-sequence aborts all pending releases and restarts timing from the reload values.
- Assertion latency: 1 cycle.
- Override deassertion latency: 1 cycle.
- Scheduled release after a falling edge: out stays low exactly MIN_ASSERT_CNT cycles minimum when the request is already 1 and sCnt=0.
- Consecutive scheduled releases are spaced at least STAGGER_CNT cycles apart.
- No combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: NUM_PCIE_SIGNALS=4, MIN_ASSERT_CNT=4, STAGGER_CNT=3. E0 is the first edge with iRst_n=1.
- Power-up release: ivDefaultValues=4'hF, no override, reset released -> ch0 rises at E3, ch1 at E6, ch2 at E9, ch3 at E12. oStaggerBusy=1 between grants. ovReleasePending walks 4'hE, 4'hC, 4'h8, 4'h0.
- Minimum width: all channels high, ivDefaultValues[2] low for 1 cycle at Ek -> out[2]=0 after Ek, rises after Ek+4 (low 4 cycles). Other outputs unchanged.
- Override bypass: at E2 after reset set ivOverride_Enable=4'h2, ivOvrValues=4'h2 -> out[1]=1 after E2, ignoring aCnt and sCnt. Set ivOvrValues[1]=0 -> out[1]=0 next edge. Ch0 release timing is unaffected.
- STAGGER_CNT=0 variant: power-up as in the first scenario -> all four outputs rise together at E3. oStaggerBusy stays 0.
- Contention and reassert: ch0 and ch2 become eligible in the same cycle -> ch0 granted first, ch2 3 cycles later. If ch0 default drops in its grant cycle -> ch2 is granted in that cycle instead, and ch0 stays low.
- Mid-operation reset: iRst_n=0 for one edge during the power-up sequence after ch1 rises -> all outputs 0 at the next edge. The sequence then restarts with ch0 at E3 relative to the new E0.

Source files
------------

// File: rtl/rst_perst_seq_if.sv
// PERST# table control and status bundle between the control registers and the sequencer.
// The master side drives the per-channel requests; the slave side returns the pin levels and status.
interface rst_perst_seq_if #(
  parameter int NUM_PCIE_SIGNALS = 7
);
  logic [NUM_PCIE_SIGNALS-1:0] ivOverride_Enable;
  logic [NUM_PCIE_SIGNALS-1:0] ivOvrValues;
  logic [NUM_PCIE_SIGNALS-1:0] ivDefaultValues;
  logic [NUM_PCIE_SIGNALS-1:0] ovRstPCIePERst_n;
  logic [NUM_PCIE_SIGNALS-1:0] ovReleasePending;
  logic                        oStaggerBusy;

  modport master (
    output ivOverride_Enable,
    output ivOvrValues,
    output ivDefaultValues,
    input  ovRstPCIePERst_n,
    input  ovReleasePending,
    input  oStaggerBusy
  );

  modport slave (
    input  ivOverride_Enable,
    input  ivOvrValues,
    input  ivDefaultValues,
    output ovRstPCIePERst_n,
    output ovReleasePending,
    output oStaggerBusy
  );
endinterface

// File: rtl/rst_perst_seq.sv
// PCIe PERST# generator: override/default select, per-channel minimum assertion width,
// and a global scheduler that releases non-overridden channels one at a time, lowest index first.
module rst_perst_seq #(
  parameter int NUM_PCIE_SIGNALS = 7,
  parameter int MIN_ASSERT_CNT   = 200,
  parameter int STAGGER_CNT      = 20
) (
  input logic            iClk,
  input logic            iRst_n,
  rst_perst_seq_if.slave bus
);

  localparam int N          = NUM_PCIE_SIGNALS;
  localparam int ACNT_W     = (MIN_ASSERT_CNT > 1) ? $clog2(MIN_ASSERT_CNT) : 1;
  localparam int SCNT_W     = (STAGGER_CNT > 0) ? $clog2(STAGGER_CNT + 1) : 1;
  localparam int S_RELOAD_I = (STAGGER_CNT > 0) ? STAGGER_CNT - 1 : 0;

  localparam logic [ACNT_W-1:0] A_RELOAD = ACNT_W'(MIN_ASSERT_CNT - 1);
  localparam logic [SCNT_W-1:0] S_RELOAD = SCNT_W'(S_RELOAD_I);

  logic [N-1:0]      ovr;
  logic [N-1:0]      eff;
  logic [N-1:0]      acnt_zero;
  logic [N-1:0]      eligible;
  logic [N-1:0]      lowest;
  logic [N-1:0]      grant;
  logic [N-1:0]      out_d;
  logic [N-1:0]      pend_d;
  logic [ACNT_W-1:0] acnt_d [N];
  logic [SCNT_W-1:0] scnt_d;

  logic [N-1:0]      out_q;
  logic [N-1:0]      pend_q;
  logic              busy_q;
  logic [ACNT_W-1:0] acnt_q [N];
  logic [SCNT_W-1:0] scnt_q;

  assign ovr = bus.ivOverride_Enable;
  assign eff = (ovr & bus.ivOvrValues) | (~ovr & bus.ivDefaultValues);

  always_comb begin
    // NOTE: every signal written here gets a default before any condition so no path can infer a latch.
    acnt_zero = '0;
    for (int i = 0; i < N; i++) begin
      acnt_zero[i] = (acnt_q[i] == '0);
    end

    eligible = ~ovr & ~out_q & eff & acnt_zero;
    // Two's-complement trick isolates the lowest set bit: the lowest-index eligible channel.
    lowest   = eligible & (~eligible + N'(1));

    if (STAGGER_CNT == 0) begin
      grant = eligible;
    end else if (scnt_q == '0) begin
      grant = lowest;
    end else begin
      grant = '0;
    end

    // Low request always wins; overrides follow eff directly; scheduled channels need a grant to rise.
    out_d  = eff & (ovr | out_q | grant);
    pend_d = ~out_d & eff & ~ovr;

    for (int i = 0; i < N; i++) begin
      acnt_d[i] = acnt_q[i];
      if (out_q[i] && !out_d[i]) begin
        acnt_d[i] = A_RELOAD;
      end else if (!out_q[i] && !acnt_zero[i]) begin
        acnt_d[i] = acnt_q[i] - ACNT_W'(1);
      end
    end

    scnt_d = scnt_q;
    if (|grant) begin
      scnt_d = S_RELOAD;
    end else if (scnt_q != '0) begin
      scnt_d = scnt_q - SCNT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: state updates use <= so each register samples pre-edge values regardless of statement order.
    if (!iRst_n) begin
      out_q  <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      scnt_q <= '0;
      // NOTE: the counter array is reset like ordinary flops, not left uninitialised like a RAM,
      // so the minimum assertion width is enforced straight out of reset.
      for (int i = 0; i < N; i++) begin
        acnt_q[i] <= A_RELOAD;
      end
    end else begin
      out_q  <= out_d;
      pend_q <= pend_d;
      busy_q <= (scnt_d != '0);
      scnt_q <= scnt_d;
      for (int i = 0; i < N; i++) begin
        acnt_q[i] <= acnt_d[i];
      end
    end
  end

  assign bus.ovRstPCIePERst_n = out_q;
  assign bus.ovReleasePending = pend_q;
  assign bus.oStaggerBusy     = busy_q;

endmodule
